// File: rtl/ks_mul_seq.sv
// ks_mul_seq: sequential Karatsuba carry-less multiplier, one shared ceil(W/2)-bit core over three cycles.
// Define KS_REDUCE_EN to reduce the product modulo POLY (result zero-extended to 2W-1 bits).
module ks_mul_seq #(
  parameter int         W    = 29,
  parameter logic [W:0] POLY = 30'h20000005
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-2:0] d
);
  localparam int HL = (W + 1) / 2;
  localparam int MW = 2 * HL - 1;
  localparam int PW = 2 * W - 1;
  typedef enum logic [2:0] {IDLE, LO, HI, MID, DONE} state_t;
  state_t        state_q, state_d;
  logic [W-1:0]  a_q, a_d, b_q, b_d;
  logic [MW-1:0] m1_q, m1_d, m2_q, m2_d;
  logic [PW-1:0] d_q, d_d, p, res;
  logic          out_valid_q, out_valid_d;
  logic [HL-1:0] a_lo, a_hi, b_lo, b_hi, ca, cb;
  logic [MW-1:0] prod;
  logic          accept;
  if (POLY[W] != 1'b1) begin : g_poly_chk
    $error("ks_mul_seq: POLY[W] must be 1");
  end
  function automatic logic [MW-1:0] clmul(input logic [HL-1:0] x, input logic [HL-1:0] y);
    logic [MW-1:0] r;
    r = '0;
    for (int i = 0; i < HL; i++) if (y[i]) r ^= MW'(x) << i;
    return r;
  endfunction
`ifdef KS_REDUCE_EN
  function automatic logic [W-1:0] reduce(input logic [PW-1:0] v);
    logic [PW-1:0] r;
    r = v;
    for (int i = PW - 1; i >= W; i--) if (r[i]) r ^= PW'(POLY) << (i - W);
    return r[W-1:0];
  endfunction
`endif
  assign a_lo      = a_q[HL-1:0];
  assign b_lo      = b_q[HL-1:0];
  assign a_hi      = HL'(a_q[W-1:HL]);
  assign b_hi      = HL'(b_q[W-1:HL]);
  assign in_ready  = (state_q == IDLE) | ((state_q == DONE) & out_ready);
  assign accept    = in_valid & in_ready;
  assign out_valid = out_valid_q;
  assign d         = d_q;
  // The single core is steered by state: LO -> m2, HI -> m1, MID -> m3 (used directly, never stored).
  always_comb begin
    ca          = state_q == HI ? a_hi : state_q == MID ? a_lo ^ a_hi : a_lo;
    cb          = state_q == HI ? b_hi : state_q == MID ? b_lo ^ b_hi : b_lo;
    prod        = clmul(ca, cb);
    p           = PW'(m2_q) ^ (PW'(m1_q ^ m2_q ^ prod) << HL) ^ (PW'(m1_q) << (2 * HL));
`ifdef KS_REDUCE_EN
    res         = PW'(reduce(p));
`else
    res         = p;
`endif
    a_d         = accept ? a : a_q;
    b_d         = accept ? b : b_q;
    m2_d        = state_q == LO ? prod : m2_q;
    m1_d        = state_q == HI ? prod : m1_q;
    d_d         = state_q == MID ? res : d_q;
    out_valid_d = (state_q == MID) | (out_valid_q & ~out_ready);
    state_d     = accept ? LO :
                  state_q == LO ? HI :
                  state_q == HI ? MID :
                  state_q == MID ? DONE :
                  (state_q == DONE & out_ready) ? IDLE : state_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      m1_q        <= '0;
      m2_q        <= '0;
      d_q         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      m1_q        <= m1_d;
      m2_q        <= m2_d;
      d_q         <= d_d;
      out_valid_q <= out_valid_d;
    end
  end
endmodule

// File: tb/tb_ks_mul_seq.sv
// tb_ks_mul_seq: directed and randomized checks of ks_mul_seq against a bit-serial carry-less reference.
module tb_ks_mul_seq;
  localparam int W  = 29;
  localparam int PW = 2 * W - 1;
  logic          clk = 1'b0;
  logic          rst, in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0]  a, b;
  logic [PW-1:0] d, r, held;
  int            n_tests = 0, n_fail = 0, lat;
  logic [PW-1:0] exp_q[$];
  always #5 clk = ~clk;
  ks_mul_seq #(.W(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .d(d)
  );
  task automatic check(input string tag, input logic [PW-1:0] got, input logic [PW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [PW-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [PW-1:0] p;
`ifdef KS_REDUCE_EN
    logic [W:0] poly;
    poly = 30'h20000005;
`endif
    p = '0;
    for (int i = 0; i < W; i++) if (y[i]) p ^= PW'(x) << i;
`ifdef KS_REDUCE_EN
    for (int i = PW - 1; i >= W; i--) if (p[i]) p ^= PW'(poly) << (i - W);
`endif
    return p;
  endfunction
  // Issue one operation from IDLE and wait (bounded) for its result; operands are scrambled after accept.
  task automatic op(input logic [W-1:0] x, input logic [W-1:0] y, output logic [PW-1:0] res, output int l);
    in_valid = 1'b1;
    a = x;
    b = y;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    l = 0;
    while (!out_valid && l < 20) begin
      @(posedge clk); #1;
      l++;
    end
    res = d;
  endtask
  task automatic handoff();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("handoff_ov", PW'(out_valid), 0);
  endtask
  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int kin, kout, last, n_done;
    logic acc;
    logic [W-1:0] z;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    check("rst_ov", PW'(out_valid), 0);
    check("rst_d", d, 0);
    check("rst_rdy", PW'(in_ready), 1);
    op(29'h3, 29'h3, r, lat);
    check("t1_d", r, 57'h5);
    check("t1_lat", PW'(lat), 3);
    handoff();
    op(29'h10000000, 29'h10000000, r, lat);
`ifdef KS_REDUCE_EN
    check("t2_d", r, 57'h08000005);
`else
    check("t2_d", r, 57'h100000000000000);
`endif
    check("t2_lat", PW'(lat), 3);
    handoff();
    op(29'h1abcdef, 29'h0123457, r, lat);
    check("t3_d", r, ref_mul(29'h1abcdef, 29'h0123457));
    held = d;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      a = W'($urandom);
      b = W'($urandom);
      @(posedge clk); #1;
      check("t3_hold_d", d, held);
      check("t3_hold_ov", PW'(out_valid), 1);
      check("t3_hold_rdy", PW'(in_ready), 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("t3_drain_ov", PW'(out_valid), 0);
    out_ready = 1'b0;
    #1 check("t3_idle_rdy", PW'(in_ready), 1);
    z = W'($urandom) | 29'h1;
    op('0, z, r, lat);
    check("zero_d", r, 0);
    check("zero_lat", PW'(lat), 3);
    handoff();
    kin = 0; kout = 0; last = -1;
    a = 29'h1; b = 29'h1; in_valid = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 60 && kout < 6; c++) begin
      acc = in_valid & in_ready;
      @(posedge clk); #1;
      if (acc) begin
        kin++;
        if (kin < 6) b = W'(1) << kin;
        else in_valid = 1'b0;
      end
      if (out_valid) begin
        check("t4_d", d, PW'(1) << kout);
        if (kout > 0) check("t4_gap", PW'(c - last), 4);
        last = c;
        kout++;
      end
    end
    check("t4_count", PW'(kout), 6);
    in_valid = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("t4_idle_rdy", PW'(in_ready), 1);
    in_valid = 1'b1; a = 29'h5; b = 29'h9;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("t5_rst_ov", PW'(out_valid), 0);
    check("t5_rst_d", d, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("t5_rdy", PW'(in_ready), 1);
    check("t5_no_ov", PW'(out_valid), 0);
    op(29'h7, 29'h5, r, lat);
    check("t5_d", r, 57'h1b);
    check("t5_lat", PW'(lat), 3);
    handoff();
    n_done = 0;
    for (int c = 0; c < 60000 && n_done < 3000; c++) begin
      in_valid = ($urandom % 4) != 0;
      out_ready = ($urandom % 4) != 0;
      a = W'($urandom);
      b = W'($urandom);
      #1;
      if (in_valid && in_ready) exp_q.push_back(ref_mul(a, b));
      if (out_valid && exp_q.size() == 0) check("rnd_spurious", PW'(out_valid), 0);
      else if (out_valid && out_ready) begin
        check("rnd_d", d, exp_q.pop_front());
        n_done++;
      end
      @(posedge clk); #1;
    end
    check("rnd_count", PW'(n_done), 3000);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
